// File: rtl/dst_tracker.sv
// rtl/dst_tracker.sv - destination/load-flag tracker for EX, MEM and WB with load-use stall control
module dst_tracker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             id_valid,
    input  logic             id_wen,
    input  logic [4:0]       id_dst,
    input  logic             id_load,
    input  logic             load_forward,
    input  logic             me_hold,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [4:0]       ex_dst,
    output logic [4:0]       me_dst,
    output logic [4:0]       wb_dst,
    output logic [2:0]       mem_load,
    output logic             id_stall,
    output logic             ex_bubble,
    output logic [CNT_W-1:0] stall_cnt
);

    // Stage entries: destination register plus "write data comes from memory" flag.
    logic [4:0]       ex_dst_q, ex_dst_d;
    logic [4:0]       me_dst_q, me_dst_d;
    logic [4:0]       wb_dst_q, wb_dst_d;
    logic             ex_ld_q, ex_ld_d;
    logic             me_ld_q, me_ld_d;
    logic             wb_ld_q, wb_ld_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [4:0]       cap_dst;
    logic             cap_ld;
    logic             load_stall;

    // Entry captured from ID; a zero destination never carries a load flag.
    always_comb begin
        cap_dst = 5'd0;
        cap_ld  = 1'b0;
        if (id_valid && id_wen) begin
            cap_dst = id_dst;
            cap_ld  = id_load && (id_dst != 5'd0);
        end
    end

    // Hold/bubble controls; flush overrides every stall source.
    always_comb begin
        load_stall = id_valid && load_forward;
        id_stall   = !flush && (me_hold || load_stall);
        ex_bubble  = !flush && !me_hold && load_stall;
    end

    // Next-state for the stage entries: flush, then memory hold, then load bubble, then normal shift.
    always_comb begin
        ex_dst_d = ex_dst_q;
        me_dst_d = me_dst_q;
        wb_dst_d = wb_dst_q;
        ex_ld_d  = ex_ld_q;
        me_ld_d  = me_ld_q;
        wb_ld_d  = wb_ld_q;
        if (flush) begin
            ex_dst_d = 5'd0;
            me_dst_d = 5'd0;
            wb_dst_d = 5'd0;
            ex_ld_d  = 1'b0;
            me_ld_d  = 1'b0;
            wb_ld_d  = 1'b0;
        end else if (me_hold) begin
            ex_dst_d = ex_dst_q;
            me_dst_d = me_dst_q;
            wb_dst_d = wb_dst_q;
            ex_ld_d  = ex_ld_q;
            me_ld_d  = me_ld_q;
            wb_ld_d  = wb_ld_q;
        end else begin
            wb_dst_d = me_dst_q;
            wb_ld_d  = me_ld_q;
            me_dst_d = ex_dst_q;
            me_ld_d  = ex_ld_q;
            if (load_stall) begin
                ex_dst_d = 5'd0;
                ex_ld_d  = 1'b0;
            end else begin
                ex_dst_d = cap_dst;
                ex_ld_d  = cap_ld;
            end
        end
    end

    // Saturating stall-cycle counter; clear beats increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (id_stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_dst_q    <= 5'd0;
            me_dst_q    <= 5'd0;
            wb_dst_q    <= 5'd0;
            ex_ld_q     <= 1'b0;
            me_ld_q     <= 1'b0;
            wb_ld_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_dst_q    <= ex_dst_d;
            me_dst_q    <= me_dst_d;
            wb_dst_q    <= wb_dst_d;
            ex_ld_q     <= ex_ld_d;
            me_ld_q     <= me_ld_d;
            wb_ld_q     <= wb_ld_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Registered outputs to the forward unit and performance monitor.
    always_comb begin
        ex_dst    = ex_dst_q;
        me_dst    = me_dst_q;
        wb_dst    = wb_dst_q;
        mem_load  = {ex_ld_q, me_ld_q, wb_ld_q};
        stall_cnt = stall_cnt_q;
    end

endmodule

// File: tb/tb_dst_tracker.sv
// tb/tb_dst_tracker.sv - scoreboard bench for dst_tracker
module tb_dst_tracker;

    logic       clk = 1'b0;
    logic       resetn;
    logic       id_valid, id_wen, id_load;
    logic [4:0] id_dst;
    logic       load_forward, me_hold, flush, cnt_clr;
    logic [4:0] ex_dst, me_dst, wb_dst;
    logic [2:0] mem_load;
    logic       id_stall, ex_bubble;
    logic [3:0] stall_cnt;

    dst_tracker #(.CNT_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .id_valid(id_valid), .id_wen(id_wen), .id_dst(id_dst), .id_load(id_load),
        .load_forward(load_forward), .me_hold(me_hold), .flush(flush), .cnt_clr(cnt_clr),
        .ex_dst(ex_dst), .me_dst(me_dst), .wb_dst(wb_dst), .mem_load(mem_load),
        .id_stall(id_stall), .ex_bubble(ex_bubble), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] ex;
        logic [4:0] me;
        logic [4:0] wb;
        logic [2:0] ml;
        logic [3:0] cnt;
    } exp_t;

    exp_t q[$];
    int   ncmp = 0;
    int   nfail = 0;

    // reference pipeline
    logic [4:0] m_dst[3];   // 0=EX 1=MEM 2=WB
    logic       m_ld[3];
    logic [3:0] m_cnt;
    logic       obs_stall, obs_bubble;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ncmp++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_dst[i] = 5'd0;
            m_ld[i]  = 1'b0;
        end
        m_cnt = 4'd0;
    endtask

    // forward unit stand-in: load hazard on source s from tracked outputs
    function automatic logic fwd(input logic [4:0] s);
        return (s != 5'd0) && ((ex_dst == s && mem_load[2]) ||
                               (me_dst == s && mem_load[1]) ||
                               (wb_dst == s && mem_load[0]));
    endfunction

    task automatic cycle(input logic v, input logic w, input logic [4:0] dst, input logic ld,
                         input logic [4:0] src, input logic flf, input logic hold,
                         input logic fl, input logic clr);
        exp_t       e;
        logic       st, bb, lf;
        logic [4:0] cd;
        logic       cl;
        id_valid = v; id_wen = w; id_dst = dst; id_load = ld;
        me_hold = hold; flush = fl; cnt_clr = clr;
        load_forward = flf | fwd(src);
        lf = load_forward;
        #1;
        st = !fl && (hold || (v && lf));
        bb = !fl && !hold && v && lf;
        chk("id_stall", id_stall, st);
        chk("ex_bubble", ex_bubble, bb);
        obs_stall  = id_stall;
        obs_bubble = ex_bubble;
        cd = (v && w) ? dst : 5'd0;
        cl = v && w && ld && (dst != 5'd0);
        if (fl) begin
            for (int i = 0; i < 3; i++) begin m_dst[i] = 5'd0; m_ld[i] = 1'b0; end
        end else if (!hold) begin
            m_dst[2] = m_dst[1]; m_ld[2] = m_ld[1];
            m_dst[1] = m_dst[0]; m_ld[1] = m_ld[0];
            m_dst[0] = (v && lf) ? 5'd0 : cd;
            m_ld[0]  = (v && lf) ? 1'b0 : cl;
        end
        if (clr) m_cnt = 4'd0;
        else if (st && m_cnt != 4'hf) m_cnt = m_cnt + 4'd1;
        e.ex = m_dst[0]; e.me = m_dst[1]; e.wb = m_dst[2];
        e.ml = {m_ld[0], m_ld[1], m_ld[2]}; e.cnt = m_cnt;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("ex_dst", ex_dst, e.ex);
        chk("me_dst", me_dst, e.me);
        chk("wb_dst", wb_dst, e.wb);
        chk("mem_load", mem_load, e.ml);
        chk("stall_cnt", stall_cnt, e.cnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int         stalls;
        logic [2:0] mlseq[3];
        logic [3:0] cnt0;
        model_reset();
        resetn = 1'b0;
        // reset with random inputs
        for (int i = 0; i < 4; i++) begin
            id_valid = 1'($urandom); id_wen = 1'($urandom); id_dst = 5'($urandom);
            id_load = 1'($urandom); load_forward = 1'($urandom); me_hold = 1'($urandom);
            flush = 1'($urandom); cnt_clr = 1'($urandom);
            @(posedge clk); #1;
            chk("rst_ex_dst", ex_dst, 0);
            chk("rst_me_dst", me_dst, 0);
            chk("rst_wb_dst", wb_dst, 0);
            chk("rst_mem_load", mem_load, 0);
            chk("rst_stall_cnt", stall_cnt, 0);
        end
        id_valid = 0; id_wen = 0; id_dst = 0; id_load = 0;
        load_forward = 0; me_hold = 0; flush = 0; cnt_clr = 0;
        #1;
        chk("rst_id_stall", id_stall, 0);
        chk("rst_ex_bubble", ex_bubble, 0);
        resetn = 1'b1;
        idle(5);

        // shift
        cycle(1, 1, 5'd3, 0, 5'd0, 0, 0, 0, 0);
        cycle(1, 1, 5'd7, 0, 5'd0, 0, 0, 0, 0);
        cycle(1, 1, 5'd9, 0, 5'd0, 0, 0, 0, 0);
        chk("shift_ex", ex_dst, 9);
        chk("shift_me", me_dst, 7);
        chk("shift_wb", wb_dst, 3);
        chk("shift_ml", mem_load, 3'b000);
        cycle(1, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0);
        chk("dst0_ld", mem_load, 3'b000);
        cycle(1, 0, 5'd4, 1, 5'd0, 0, 0, 0, 0);
        chk("nowen_ex", ex_dst, 0);
        cycle(0, 1, 5'd4, 1, 5'd0, 0, 0, 0, 0);
        chk("novalid_ex", ex_dst, 0);
        idle(3);

        // load-use with counter cleared first
        cycle(0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1);
        cycle(1, 1, 5'd5, 1, 5'd0, 0, 0, 0, 0);
        chk("lu_ml_ex", mem_load, 3'b100);
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 5'd8, 0, 5'd5, 0, 0, 0, 0);
            if (!obs_stall) break;
            if (stalls < 3) mlseq[stalls] = mem_load;
            stalls++;
            chk("lu_ex_bubble_dst", ex_dst, 0);
        end
        chk("lu_stalls", stalls, 3);
        chk("lu_ml1", mlseq[0], 3'b010);
        chk("lu_ml2", mlseq[1], 3'b001);
        chk("lu_ml3", mlseq[2], 3'b000);
        chk("lu_dep_ex", ex_dst, 8);
        chk("lu_cnt", stall_cnt, 3);

        // memory hold
        cycle(1, 1, 5'd6, 0, 5'd0, 0, 0, 0, 0);
        cycle(1, 1, 5'd4, 0, 5'd0, 0, 0, 0, 0);
        cycle(1, 1, 5'd2, 0, 5'd0, 0, 0, 0, 0);
        cnt0 = stall_cnt;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 5'd11, 0, 5'd0, 0, 1, 0, 0);
            chk("hold_stall", obs_stall, 1);
            chk("hold_bubble", obs_bubble, 0);
        end
        chk("hold_ex", ex_dst, 2);
        chk("hold_me", me_dst, 4);
        chk("hold_wb", wb_dst, 6);
        chk("hold_cnt", stall_cnt, cnt0 + 4'd4);
        cycle(1, 1, 5'd11, 0, 5'd0, 0, 0, 0, 0);
        chk("rel_ex", ex_dst, 11);
        chk("rel_me", me_dst, 2);
        chk("rel_wb", wb_dst, 4);

        // load stall under memory hold: freeze, no bubble
        cycle(1, 1, 5'd5, 1, 5'd0, 0, 0, 0, 0);
        cycle(1, 1, 5'd9, 0, 5'd5, 0, 1, 0, 0);
        chk("hls_bubble", obs_bubble, 0);
        chk("hls_ex", ex_dst, 5);

        // flush priority
        cycle(1, 1, 5'd13, 0, 5'd0, 1, 1, 1, 0);
        chk("fl_stall", obs_stall, 0);
        chk("fl_bubble", obs_bubble, 0);
        chk("fl_ex", ex_dst, 0);
        chk("fl_me", me_dst, 0);
        chk("fl_wb", wb_dst, 0);
        chk("fl_ml", mem_load, 0);

        // asynchronous reset mid-stall
        cycle(1, 1, 5'd12, 1, 5'd0, 0, 0, 0, 0);
        cycle(1, 1, 5'd1, 0, 5'd0, 0, 1, 0, 0);
        cycle(1, 1, 5'd1, 0, 5'd0, 0, 1, 0, 0);
        resetn = 1'b0;
        #1;
        chk("amid_ex", ex_dst, 0);
        chk("amid_ml", mem_load, 0);
        chk("amid_cnt", stall_cnt, 0);
        model_reset();
        me_hold = 0; id_valid = 0;
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(1);

        // saturation and clear
        for (int i = 0; i < 20; i++) cycle(0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0);
        chk("sat_cnt", stall_cnt, 15);
        cycle(0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1);
        chk("clr_stall", obs_stall, 1);
        chk("clr_cnt", stall_cnt, 0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/dst_tracker.md
# dst_tracker

Producer side of the operand-forwarding interface. Tracks the destination register and load flag of every instruction in flight through EX, MEM and WB, and drives `ex_dst`, `me_dst`, `wb_dst` and `mem_load` to the forward unit. Consumes that unit's `load_forward` response and a memory-wait hold to stall ID and insert bubbles into EX. Keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID stage holds a valid instruction.
- `id_wen`  in  1  ID instruction writes a GPR.
- `id_dst`  in  5  ID instruction destination register.
- `id_load`  in  1  ID instruction's write data comes from memory.
- `load_forward`  in  1  hazard response from the forward unit; combinational function of this block's registered outputs.
- `me_hold`  in  1  MEM waiting on data memory; freezes the whole tracker.
- `flush`  in  1  exception/ERET flush of EX/MEM/WB.
- `cnt_clr`  in  1  synchronous clear of `stall_cnt`.
- `ex_dst`, `me_dst`, `wb_dst`  out  5 each  tracked destinations; 0 means no write.
- `mem_load`  out  3  load flags: [2]=EX, [1]=MEM, [0]=WB.
- `id_stall`  out  1  ID/IF must hold this cycle.
- `ex_bubble`  out  1  EX receives a bubble at the next edge.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `id_stall`=1.

## Operation
- State is three stage entries {dst[4:0], ld}, for EX, MEM and WB, plus `stall_cnt`. Outputs are driven directly from the registers.
- Entry capture from ID:
  - dst = `id_valid && id_wen` ? `id_dst` : 0.
  - ld = `id_valid && id_wen && id_load && id_dst!=0`.
  - dst=0 always forces ld=0 (invariant on every stage).
- Combinational controls:
  - `id_stall` = !flush && (me_hold || (id_valid && load_forward)).
  - `ex_bubble` = !flush && !me_hold && id_valid && load_forward.
- Per-edge update, priority order:
  - **flush:** all three entries cleared to 0. `stall_cnt` unaffected except by `cnt_clr`.
  - **me_hold:** all entries keep their values (EX, MEM and WB are frozen).
  - **load stall** (id_valid && load_forward): WB<=MEM, MEM<=EX, EX<=0 (bubble).
  - **normal:** WB<=MEM, MEM<=EX, EX<=captured ID entry. The old WB entry retires.
- `load_forward` is sampled every cycle as given. The tracker adds no stall-length limit. A load hazard clears on its own once the load leaves WB, because bubbles drain it.
- Counter:
  - Increments by 1 on every edge where `id_stall`=1.
  - Saturates at all-ones with no wrap.
  - `cnt_clr` has priority over increment (result is 0).

## Timing
- Reset (asynchronous, `resetn`=0): all dst=0, `mem_load`=3'b000, `stall_cnt`=0. `id_stall`/`ex_bubble` follow their equations and evaluate 0 when `load_forward`=0, `me_hold`=0 and `flush`=0. Deassertion is sampled at the next rising edge.
- Latency:
  - ID entry appears on `ex_dst` 1 cycle after capture, `me_dst` after 2, `wb_dst` after 3, and is gone after 4 (absent stalls).
- Load-use case:
  - Load enters EX at cycle t; dependent sits in ID.
  - `id_stall`=1 in cycles t, t+1, t+2.
  - Dependent captured at edge end of t+3. That is 3 bubbles.
- Simultaneous events:
  - flush+me_hold: flush wins.
  - flush+load stall: flush wins, `id_stall`=0.
  - `me_hold` during a load stall: freeze, no bubble, counter still increments.
- Reset mid-stall: state clears immediately and the counter returns to 0.
- No combinational path from `load_forward` to any register output. There is a path only to `id_stall`/`ex_bubble`.

## Test plan
- **Reset/idle:** hold `resetn`=0 with random inputs → all outputs 0. Release with `id_valid`=0 for 5 cycles → dst 0, `mem_load`=0, `stall_cnt`=0.
- **Shift:** issue dst 3, 7, 9 (non-load) on consecutive cycles → cycle 3 shows ex=9, me=7, wb=3, `mem_load`=000. Dst 0 with `id_load`=1 → ld stays 0.
- **Load-use:** load r5 then dependent with `load_forward` modelled from outputs → `id_stall` high exactly 3 cycles. `mem_load` sequence 100, 010, 001 with EX=0 behind. `stall_cnt`=3.
- **Memory hold:** `me_hold`=1 for 4 cycles with ex=2/me=4/wb=6 → entries frozen. `id_stall`=1, `ex_bubble`=0, `stall_cnt`+4. Release → shifting resumes.
- **Flush priority:** assert flush together with `me_hold` and `load_forward` → next cycle all entries 0. `id_stall`=0 during flush.
- **Counter saturation/clear:** CNT_W=4, stall 20 cycles → `stall_cnt`=15 held. `cnt_clr` with `id_stall`=1 → 0.
